data_memory_arbiter: RTL and testbench

- Shares the single-port data memory between the pipeline MEM stage (CPU port) and a host loader/debug port (HOST port).
- Sits between the ex_mem register outputs and the data_memory instance. Drives a stall to freeze the pipeline whenever the host owns the memory.
- CPU has priority. A bounded-burst counter guarantees the host is never starved.

---
 rtl/data_memory_arbiter_pkg.sv | 13 +
 rtl/data_memory_arbiter_saturating_counter.sv | 31 +++
 rtl/data_memory_arbiter.sv | 125 ++++++++++++
 tb/tb_data_memory_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the data memory arbiter: data/address width and the
// arbiter state encoding.
package data_memory_arbiter_pkg;

    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        HOST_GRANT = 2'd1,
        HOST_ACK   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/data_memory_arbiter_saturating_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module saturating_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/data_memory_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage and a host
// loader port. CPU has priority; a burst counter bounds how long the host waits.
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int unsigned MAX_CPU_BURST = 4,
    parameter int unsigned STALL_CNT_W   = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [DATA_W-1:0]      cpu_addr,
    input  logic [DATA_W-1:0]      cpu_wdata,
    output logic [DATA_W-1:0]      cpu_rdata,
    output logic                   cpu_stall,
    input  logic                   host_req,
    input  logic                   host_we,
    input  logic [DATA_W-1:0]      host_addr,
    input  logic [DATA_W-1:0]      host_wdata,
    output logic                   host_ack,
    output logic [DATA_W-1:0]      host_rdata,
    output logic [DATA_W-1:0]      mem_address,
    output logic [DATA_W-1:0]      mem_data,
    output logic                   mem_wren,
    input  logic [DATA_W-1:0]      mem_q,
    output logic                   host_owner,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int unsigned BURST_W = $clog2(MAX_CPU_BURST + 1);

    arb_state_e          state_q, state_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic                host_ack_q, host_ack_d;
    logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;
    logic                grant;
    arb_state_e          phase;

    // The grant is decided combinationally in IDLE; phase relabels that cycle
    // as HOST_GRANT so the mux and next-state logic see one memory cycle.
    always_comb begin
        grant = reset && (state_q == IDLE) && host_req &&
                (!cpu_req || (burst_q == BURST_W'(MAX_CPU_BURST)));
        phase = grant ? HOST_GRANT : state_q;

        state_d      = state_q;
        burst_d      = burst_q;
        host_ack_d   = 1'b0;
        host_rdata_d = host_rdata_q;

        case (phase)
            IDLE: begin
                if (host_req && cpu_req) begin
                    burst_d = burst_q + BURST_W'(1);
                end else begin
                    burst_d = '0;
                end
            end
            HOST_GRANT: begin
                state_d    = HOST_ACK;
                burst_d    = '0;
                host_ack_d = 1'b1;
                if (!host_we) begin
                    host_rdata_d = mem_q;
                end
            end
            HOST_ACK: begin
                state_d = IDLE;
                burst_d = '0;
            end
            default: begin
                state_d = IDLE;
                burst_d = '0;
            end
        endcase
    end

    always_comb begin
        mem_address = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
        if (reset) begin
            if (phase == HOST_GRANT) begin
                mem_address = host_addr;
                mem_data    = host_wdata;
                mem_wren    = host_we;
            end else begin
                mem_address = cpu_addr;
                mem_data    = cpu_wdata;
                mem_wren    = cpu_req & cpu_we;
            end
        end
        host_owner = grant;
        cpu_stall  = grant & cpu_req;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            burst_q      <= '0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            burst_q      <= burst_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign cpu_rdata  = mem_q;
    assign host_ack   = host_ack_q;
    assign host_rdata = host_rdata_q;

    saturating_counter #(
        .W(STALL_CNT_W)
    ) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (cpu_stall),
        .count (stall_count)
    );

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed self-checking bench for data_memory_arbiter with a negedge-clocked
// memory model; a second instance with a 2-bit stall counter covers saturation.
module tb_data_memory_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req, cpu_we, host_req, host_we;
    logic [15:0] cpu_addr, cpu_wdata, host_addr, host_wdata;

    logic [15:0] cpu_rdata, host_rdata, mem_address, mem_data, stall_count;
    logic        cpu_stall, host_ack, mem_wren, host_owner;
    logic [15:0] mem_q;

    logic [15:0] s_cpu_rdata, s_host_rdata, s_mem_address, s_mem_data;
    logic        s_cpu_stall, s_host_ack, s_mem_wren, s_host_owner;
    logic [1:0]  s_stall_count;

    logic [15:0] mem [0:255];

    int pass_cnt  = 0;
    int check_cnt = 0;

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (mem_wren) mem[mem_address[7:0]] <= mem_data;
        mem_q <= mem[mem_address[7:0]];
    end

    data_memory_arbiter #(.MAX_CPU_BURST(4), .STALL_CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
        .host_owner(host_owner), .stall_count(stall_count)
    );

    data_memory_arbiter #(.MAX_CPU_BURST(4), .STALL_CNT_W(2)) u_sat (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(s_cpu_rdata), .cpu_stall(s_cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(s_host_ack), .host_rdata(s_host_rdata),
        .mem_address(s_mem_address), .mem_data(s_mem_data), .mem_wren(s_mem_wren), .mem_q(mem_q),
        .host_owner(s_host_owner), .stall_count(s_stall_count)
    );

    typedef struct {
        logic        cpu_req;
        logic        cpu_we;
        logic [15:0] cpu_addr;
        logic [15:0] cpu_wdata;
        logic        host_req;
        logic        host_we;
        logic [15:0] host_addr;
        logic [15:0] host_wdata;
        logic        e_stall;
        logic        e_owner;
        logic        e_ack;
        logic        e_wren;
        logic [15:0] e_addr;
        logic [15:0] e_data;
        logic [15:0] e_sc;
        logic [15:0] e_hrd;
        logic        chk_rd;
        logic [15:0] e_rd;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mkv(
        input logic cr, input logic cw, input logic [15:0] ca, input logic [15:0] cd,
        input logic hr, input logic hw, input logic [15:0] ha, input logic [15:0] hd,
        input logic es, input logic eo, input logic ek, input logic ew,
        input logic [15:0] ea, input logic [15:0] ed, input logic [15:0] esc,
        input logic [15:0] ehr, input logic crd, input logic [15:0] erd);
        vec_t v;
        v.cpu_req = cr;  v.cpu_we = cw;  v.cpu_addr = ca;  v.cpu_wdata = cd;
        v.host_req = hr; v.host_we = hw; v.host_addr = ha; v.host_wdata = hd;
        v.e_stall = es;  v.e_owner = eo; v.e_ack = ek;     v.e_wren = ew;
        v.e_addr = ea;   v.e_data = ed;  v.e_sc = esc;     v.e_hrd = ehr;
        v.chk_rd = crd;  v.e_rd = erd;
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic settle();
        @(negedge clock);
        #2;
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input vec_t v);
        cpu_req   = v.cpu_req;   cpu_we    = v.cpu_we;
        cpu_addr  = v.cpu_addr;  cpu_wdata = v.cpu_wdata;
        host_req  = v.host_req;  host_we   = v.host_we;
        host_addr = v.host_addr; host_wdata = v.host_wdata;
    endtask

    initial begin
        int k;
        // Starvation bound: host waits exactly 4 CPU grants, then one stall cycle.
        vecs[0] = mkv(1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 1'b0, 16'h0041, 16'hDEAD,
                      1'b0, 1'b0, 1'b0, 1'b1, 16'h0020, 16'h1234, 16'd0, 16'h0000, 1'b0, 16'h0);
        vecs[1] = mkv(1'b1, 1'b1, 16'h0041, 16'hA001, 1'b1, 1'b0, 16'h0041, 16'hDEAD,
                      1'b0, 1'b0, 1'b0, 1'b1, 16'h0041, 16'hA001, 16'd0, 16'h0000, 1'b0, 16'h0);
        vecs[2] = mkv(1'b1, 1'b1, 16'h0042, 16'hA002, 1'b1, 1'b0, 16'h0041, 16'hDEAD,
                      1'b0, 1'b0, 1'b0, 1'b1, 16'h0042, 16'hA002, 16'd0, 16'h0000, 1'b0, 16'h0);
        vecs[3] = mkv(1'b1, 1'b1, 16'h0043, 16'hA003, 1'b1, 1'b0, 16'h0041, 16'hDEAD,
                      1'b0, 1'b0, 1'b0, 1'b1, 16'h0043, 16'hA003, 16'd0, 16'h0000, 1'b0, 16'h0);
        vecs[4] = mkv(1'b1, 1'b1, 16'h0044, 16'hA004, 1'b1, 1'b0, 16'h0041, 16'hDEAD,
                      1'b0, 1'b0, 1'b0, 1'b1, 16'h0044, 16'hA004, 16'd0, 16'h0000, 1'b0, 16'h0);
        vecs[5] = mkv(1'b1, 1'b1, 16'h0045, 16'hA005, 1'b1, 1'b0, 16'h0041, 16'hDEAD,
                      1'b1, 1'b1, 1'b0, 1'b0, 16'h0041, 16'hDEAD, 16'd0, 16'h0000, 1'b0, 16'h0);
        vecs[6] = mkv(1'b1, 1'b1, 16'h0045, 16'hA005, 1'b1, 1'b0, 16'h0041, 16'hDEAD,
                      1'b0, 1'b0, 1'b1, 1'b1, 16'h0045, 16'hA005, 16'd1, 16'hA001, 1'b0, 16'h0);
        vecs[7] = mkv(1'b0, 1'b0, 16'h0041, 16'h0000, 1'b0, 1'b0, 16'h0041, 16'hDEAD,
                      1'b0, 1'b0, 1'b0, 1'b0, 16'h0041, 16'h0000, 16'd1, 16'hA001, 1'b1, 16'hA001);
        vecs[8] = mkv(1'b1, 1'b0, 16'h0045, 16'h0000, 1'b0, 1'b0, 16'h0041, 16'hDEAD,
                      1'b0, 1'b0, 1'b0, 1'b0, 16'h0045, 16'h0000, 16'd1, 16'hA001, 1'b1, 16'hA005);

        // Reset with both requests active: everything held inert.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0033; cpu_wdata = 16'h3333;
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0055; host_wdata = 16'h5555;
        repeat (2) @(posedge clock);
        #1;
        settle();
        chk1 ("rst_owner", host_owner, 1'b0);
        chk1 ("rst_wren", mem_wren, 1'b0);
        chk1 ("rst_stall", cpu_stall, 1'b0);
        chk1 ("rst_ack", host_ack, 1'b0);
        chk16("rst_addr", mem_address, 16'h0000);
        chk16("rst_data", mem_data, 16'h0000);
        chk16("rst_sc", stall_count, 16'h0000);
        chk16("rst_hrd", host_rdata, 16'h0000);
        nxt();
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i]);
            settle();
            chk1 ($sformatf("v%0d_stall", i), cpu_stall, vecs[i].e_stall);
            chk1 ($sformatf("v%0d_owner", i), host_owner, vecs[i].e_owner);
            chk1 ($sformatf("v%0d_ack", i), host_ack, vecs[i].e_ack);
            chk1 ($sformatf("v%0d_wren", i), mem_wren, vecs[i].e_wren);
            chk16($sformatf("v%0d_addr", i), mem_address, vecs[i].e_addr);
            chk16($sformatf("v%0d_data", i), mem_data, vecs[i].e_data);
            chk16($sformatf("v%0d_sc", i), stall_count, vecs[i].e_sc);
            chk16($sformatf("v%0d_hrd", i), host_rdata, vecs[i].e_hrd);
            if (vecs[i].chk_rd) chk16($sformatf("v%0d_rdata", i), cpu_rdata, vecs[i].e_rd);
            nxt();
        end

        // Idle host write, then a CPU read of the same word.
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0010; host_wdata = 16'hBEEF;
        settle();
        chk1 ("hw_owner", host_owner, 1'b1);
        chk1 ("hw_wren", mem_wren, 1'b1);
        chk1 ("hw_stall", cpu_stall, 1'b0);
        chk1 ("hw_ack_early", host_ack, 1'b0);
        chk16("hw_addr", mem_address, 16'h0010);
        chk16("hw_data", mem_data, 16'hBEEF);
        nxt();
        settle();
        chk1 ("hw_ack", host_ack, 1'b1);
        chk1 ("hw_ack_wren", mem_wren, 1'b0);
        chk1 ("hw_ack_owner", host_owner, 1'b0);
        chk16("hw_hrd_held", host_rdata, 16'hA001);
        nxt();
        host_req = 1'b0; cpu_req = 1'b1; cpu_addr = 16'h0010;
        settle();
        chk16("hw_cpu_rd", cpu_rdata, 16'hBEEF);
        chk1 ("hw_cpu_stall", cpu_stall, 1'b0);
        chk1 ("hw_ack_done", host_ack, 1'b0);
        chk16("hw_sc", stall_count, 16'd1);
        nxt();

        // Host read with the CPU idle.
        cpu_req = 1'b0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0020; host_wdata = 16'h0000;
        settle();
        chk1 ("hr_owner", host_owner, 1'b1);
        chk1 ("hr_ack_early", host_ack, 1'b0);
        nxt();
        settle();
        chk1 ("hr_ack", host_ack, 1'b1);
        chk16("hr_rdata", host_rdata, 16'h1234);
        nxt();
        host_req = 1'b0;
        settle();
        chk1 ("hr_ack_once", host_ack, 1'b0);
        chk16("hr_rdata_held", host_rdata, 16'h1234);
        nxt();

        // Three back-to-back host reads under continuous CPU writes.
        k = 0;
        for (int h = 0; h < 3; h++) begin
            host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0041 + 16'(h);
            for (int c = 0; c < 4; c++) begin
                cpu_req = 1'b1; cpu_we = 1'b1;
                cpu_addr = 16'h0080 + 16'(k); cpu_wdata = 16'hC000 + 16'(k);
                settle();
                chk1 ($sformatf("cl%0d_%0d_stall", h, c), cpu_stall, 1'b0);
                chk16($sformatf("cl%0d_%0d_addr", h, c), mem_address, 16'h0080 + 16'(k));
                nxt();
                k++;
            end
            cpu_addr = 16'h0080 + 16'(k); cpu_wdata = 16'hC000 + 16'(k);
            settle();
            chk1 ($sformatf("cl%0d_grant_stall", h), cpu_stall, 1'b1);
            chk16($sformatf("cl%0d_grant_addr", h), mem_address, 16'h0041 + 16'(h));
            nxt();
            settle();
            chk1 ($sformatf("cl%0d_ack", h), host_ack, 1'b1);
            chk1 ($sformatf("cl%0d_ack_wren", h), mem_wren, 1'b1);
            chk16($sformatf("cl%0d_hrd", h), host_rdata, 16'hA001 + 16'(h));
            nxt();
            k++;
        end
        host_req = 1'b0; cpu_we = 1'b0;
        settle();
        chk16("cl_sc", stall_count, 16'd4);
        nxt();
        for (int j = 0; j < 15; j++) begin
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0080 + 16'(j);
            settle();
            chk16($sformatf("cl_mem%0d", j), cpu_rdata, 16'hC000 + 16'(j));
            nxt();
        end

        // Reset asserted in the middle of a host grant cycle.
        cpu_req = 1'b0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0010; host_wdata = 16'h7777;
        #2;
        chk1("mr_owner_pre", host_owner, 1'b1);
        reset = 1'b0;
        settle();
        chk1 ("mr_wren", mem_wren, 1'b0);
        chk1 ("mr_owner", host_owner, 1'b0);
        chk16("mr_addr", mem_address, 16'h0000);
        chk16("mr_sc", stall_count, 16'h0000);
        nxt();
        settle();
        chk1("mr_ack", host_ack, 1'b0);
        nxt();
        reset = 1'b1;
        host_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        settle();
        chk1 ("mr_post_ack", host_ack, 1'b0);
        chk1 ("mr_post_stall", cpu_stall, 1'b0);
        chk16("mr_post_rd", cpu_rdata, 16'hBEEF);
        chk16("mr_post_hrd", host_rdata, 16'h0000);
        nxt();

        // Five forced stalls: 2-bit counter must hold at 3.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0020;
        repeat (18) nxt();
        settle();
        chk16("sat_sc3", {14'b0, s_stall_count}, 16'd3);
        nxt();
        repeat (11) nxt();
        host_req = 1'b0;
        settle();
        chk16("sat_sc_hold", {14'b0, s_stall_count}, 16'd3);
        chk16("sat_sc_wide", stall_count, 16'd5);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
